// File: rtl/ram_banked_wb.sv
// Banked byte-lane scratch RAM behind a Wishbone-classic slave port.
// DEPTH/512 banks of WIDTH/8 ram512x8 macros, with an optional post-reset zero-clear.

module ram512x8 (
   input  logic       clk_i,
   input  logic       cen_i,
   input  logic       wen_i,
   input  logic [8:0] addr_i,
   input  logic [7:0] d_i,
   output logic [7:0] q_o
);
   logic [7:0] mem_q [512];
   logic [7:0] q_q;

   always_ff @(posedge clk_i) begin
      if (cen_i) begin
         if (wen_i) mem_q[addr_i] <= d_i;
         q_q <= mem_q[addr_i];
      end
   end

   assign q_o = q_q;
endmodule

module ram_banked_wb #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 1024,
   parameter int INIT_CLEAR = 1,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 cyc_i,
   input  logic                 stb_i,
   input  logic                 we_i,
   input  logic [WIDTH/8-1:0]   sel_i,
   input  logic [AW-1:0]        adr_i,
   input  logic [WIDTH-1:0]     dat_i,
   output logic [WIDTH-1:0]     dat_o,
   output logic                 ack_o,
   output logic                 busy_o
);
   localparam int LANES = WIDTH / 8;
   localparam int BANKS = DEPTH / 512;
   localparam int BW    = (BANKS > 1) ? $clog2(BANKS) : 1;

   typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_ACK} state_t;

   state_t            state_q, state_d;
   logic [8:0]        clr_cnt_q, clr_cnt_d;
   logic [BW-1:0]     bank_q, bank_d;
   logic              rd_q, rd_d;
   logic              ack_q, ack_d;
   logic [WIDTH-1:0]  dat_q, dat_d;

   logic [BW-1:0]                 bank_idx;
   logic [BANKS-1:0]              cen;
   logic [BANKS-1:0][LANES-1:0]   wen;
   logic [8:0]                    row;
   logic [WIDTH-1:0]              wdata;
   logic [WIDTH-1:0]              rd_word;
   logic [7:0]                    q [BANKS][LANES];

   generate
      if (BANKS > 1) begin : g_bank_idx
         assign bank_idx = adr_i[AW-1:9];
      end else begin : g_single_bank
         assign bank_idx = 1'b0;
      end
   endgenerate

   always_comb begin
      rd_word = '0;
      for (int l = 0; l < LANES; l++) rd_word[8*l +: 8] = q[bank_q][l];
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      bank_d    = bank_q;
      rd_d      = rd_q;
      ack_d     = 1'b0;
      dat_d     = dat_q;
      cen       = '0;
      wen       = '0;
      row       = adr_i[8:0];
      wdata     = dat_i;
      case (state_q)
         ST_CLEAR: begin
            // every macro writes the same row in parallel, so a clear takes 512 cycles regardless of DEPTH
            cen       = '1;
            wen       = '1;
            row       = clr_cnt_q;
            wdata     = '0;
            clr_cnt_d = clr_cnt_q + 9'd1;
            if (clr_cnt_q == 9'd511) state_d = ST_IDLE;
         end
         ST_IDLE: begin
            if (cyc_i && stb_i) begin
               cen[bank_idx] = 1'b1;
               if (we_i) wen[bank_idx] = sel_i;
               bank_d  = bank_idx;
               rd_d    = ~we_i;
               ack_d   = 1'b1;
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            state_d = ST_IDLE;
            if (rd_q) dat_d = rd_word;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
         clr_cnt_q <= '0;
         bank_q    <= '0;
         rd_q      <= 1'b0;
         ack_q     <= 1'b0;
         dat_q     <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         bank_q    <= bank_d;
         rd_q      <= rd_d;
         ack_q     <= ack_d;
         dat_q     <= dat_d;
      end
   end

   genvar b, l;
   generate
      for (b = 0; b < BANKS; b++) begin : g_bank
         for (l = 0; l < LANES; l++) begin : g_lane
            ram512x8 u_mem (
               .clk_i  (clk_i),
               .cen_i  (cen[b]),
               .wen_i  (wen[b][l]),
               .addr_i (row),
               .d_i    (wdata[8*l +: 8]),
               .q_o    (q[b][l])
            );
         end
      end
   endgenerate

   // the macro output register already holds the read word during ACK; dat_q keeps it afterwards
   assign dat_o  = (state_q == ST_ACK && rd_q) ? rd_word : dat_q;
   assign ack_o  = ack_q;
   assign busy_o = (state_q == ST_CLEAR);
endmodule

// File: tb/tb_ram_banked_wb.sv
// Bench for ram_banked_wb: default 32x1024 cleared instance and a 16x2048 uncleared instance.
module tb_ram_banked_wb;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, cyc_a, stb_a, we_a, ack_a, busy_a;
   logic [3:0]  sel_a;
   logic [9:0]  adr_a;
   logic [31:0] din_a, dout_a;

   logic        rst_b, cyc_b, stb_b, we_b, ack_b, busy_b;
   logic [1:0]  sel_b;
   logic [10:0] adr_b;
   logic [15:0] din_b, dout_b;

   ram_banked_wb dut_a (
      .clk_i(clk), .rst_i(rst_a), .cyc_i(cyc_a), .stb_i(stb_a), .we_i(we_a),
      .sel_i(sel_a), .adr_i(adr_a), .dat_i(din_a), .dat_o(dout_a),
      .ack_o(ack_a), .busy_o(busy_a)
   );

   ram_banked_wb #(.WIDTH(16), .DEPTH(2048), .INIT_CLEAR(0)) dut_b (
      .clk_i(clk), .rst_i(rst_b), .cyc_i(cyc_b), .stb_i(stb_b), .we_i(we_b),
      .sel_i(sel_b), .adr_i(adr_b), .dat_i(din_b), .dat_o(dout_b),
      .ack_o(ack_b), .busy_o(busy_b)
   );

   int n_cmp = 0;
   int n_fail = 0;

   bit [31:0] mem_a [1024];
   bit [15:0] mem_b [2048];
   bit        vld_b [2048];
   bit [31:0] last_a;
   bit [15:0] last_b;

   typedef struct {
      bit        we;
      bit [3:0]  sel;
      bit [9:0]  adr;
      bit [31:0] dat;
      bit [31:0] exp;
   } vec_t;
   vec_t tv [10];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] d, input bit [3:0] s);
      bit [31:0] r = old;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // called at a negedge; returns at the negedge after the ack cycle
   task automatic xfer_a(input bit we, input bit [3:0] sel, input bit [9:0] adr,
                         input bit [31:0] dat, output bit [31:0] rd, output int lat);
      cyc_a = 1; stb_a = 1; we_a = we; sel_a = sel; adr_a = adr; din_a = dat; lat = 0;
      do begin @(negedge clk); lat++; end while (!ack_a && lat < 1500);
      if (!ack_a) chk("a_ack_timeout", 0, 1);
      rd = dout_a;
      cyc_a = 0; stb_a = 0;
      @(negedge clk);
      chk("a_ack_single", ack_a, 0);
   endtask

   task automatic xfer_b(input bit we, input bit [1:0] sel, input bit [10:0] adr,
                         input bit [15:0] dat, output bit [15:0] rd, output int lat);
      cyc_b = 1; stb_b = 1; we_b = we; sel_b = sel; adr_b = adr; din_b = dat; lat = 0;
      do begin @(negedge clk); lat++; end while (!ack_b && lat < 1500);
      if (!ack_b) chk("b_ack_timeout", 0, 1);
      rd = dout_b;
      cyc_b = 0; stb_b = 0;
      @(negedge clk);
      chk("b_ack_single", ack_b, 0);
   endtask

   task automatic check_a(input string nm, input bit we, input bit [3:0] sel, input bit [9:0] adr,
                          input bit [31:0] dat, input bit [31:0] rd, input int lat);
      chk({nm, "_lat"}, lat, 1);
      if (we) begin
         chk({nm, "_wr_hold"}, rd, last_a);
         mem_a[adr] = merge(mem_a[adr], dat, sel);
      end else begin
         chk({nm, "_rd"}, rd, mem_a[adr]);
         last_a = rd;
      end
   endtask

   task automatic wait_clear(input string nm);
      int cnt = 0;
      while (busy_a && cnt < 2000) begin cnt++; @(negedge clk); end
      chk(nm, cnt, 512);
      foreach (mem_a[i]) mem_a[i] = '0;
      last_a = '0;
   endtask

   initial begin
      bit [31:0] rd;
      bit [15:0] rdb;
      int lat, acks;
      bit we;
      bit [3:0] sel;
      bit [9:0] adr;
      bit [31:0] dat;
      bit [10:0] adrb;
      bit [15:0] datb;
      bit [10:0] bnd [4];

      rst_a = 1; cyc_a = 0; stb_a = 0; we_a = 0; sel_a = 0; adr_a = 0; din_a = 0;
      rst_b = 1; cyc_b = 0; stb_b = 0; we_b = 0; sel_b = 0; adr_b = 0; din_b = 0;
      repeat (3) @(negedge clk);
      rst_a = 0; rst_b = 0;
      chk("rst_ack_a", ack_a, 0);
      chk("rst_dat_a", dout_a, 0);
      chk("rst_busy_a", busy_a, 1);
      chk("rst_ack_b", ack_b, 0);
      chk("rst_dat_b", dout_b, 0);
      chk("rst_busy_b", busy_b, 0);
      wait_clear("clear_len");

      tv[0] = '{0, 4'hF, 10'h000, 32'h0, 32'h0};
      tv[1] = '{0, 4'hF, 10'h1FF, 32'h0, 32'h0};
      tv[2] = '{0, 4'hF, 10'h200, 32'h0, 32'h0};
      tv[3] = '{0, 4'hF, 10'h3FF, 32'h0, 32'h0};
      tv[4] = '{1, 4'hF, 10'h005, 32'hDEADBEEF, 32'h0};
      tv[5] = '{0, 4'h0, 10'h005, 32'h0, 32'hDEADBEEF};
      tv[6] = '{1, 4'hF, 10'h205, 32'h11223344, 32'h0};
      tv[7] = '{1, 4'h5, 10'h205, 32'hAABBCCDD, 32'h0};
      tv[8] = '{0, 4'hF, 10'h205, 32'h0, 32'h11BB33DD};
      tv[9] = '{0, 4'hF, 10'h005, 32'h0, 32'hDEADBEEF};
      for (int i = 0; i < 10; i++) begin
         xfer_a(tv[i].we, tv[i].sel, tv[i].adr, tv[i].dat, rd, lat);
         chk($sformatf("vec%0d_lat", i), lat, 1);
         if (tv[i].we) begin
            chk($sformatf("vec%0d_hold", i), rd, last_a);
            mem_a[tv[i].adr] = merge(mem_a[tv[i].adr], tv[i].dat, tv[i].sel);
         end else begin
            chk($sformatf("vec%0d_rd", i), rd, tv[i].exp);
            last_a = rd;
         end
      end

      for (int i = 0; i < 150; i++) begin
         we = 1'($urandom_range(0, 1));
         sel = 4'($urandom);
         adr = 10'($urandom);
         dat = $urandom;
         xfer_a(we, sel, adr, dat, rd, lat);
         check_a("rand_a", we, sel, adr, dat, rd, lat);
      end

      // back-to-back write then read of the same word
      xfer_a(1, 4'hF, 10'h2AA, 32'hCAFEF00D, rd, lat);
      check_a("raw_wr", 1, 4'hF, 10'h2AA, 32'hCAFEF00D, rd, lat);
      xfer_a(0, 4'hF, 10'h2AA, 32'h0, rd, lat);
      check_a("raw_rd", 0, 4'hF, 10'h2AA, 32'h0, rd, lat);

      // 16x2048 instance: boundary words, then randomized traffic
      xfer_b(1, 2'b11, 11'h7FF, 16'hA5C3, rdb, lat);
      mem_b[11'h7FF] = 16'hA5C3; vld_b[11'h7FF] = 1;
      xfer_b(1, 2'b11, 11'h000, 16'h5A3C, rdb, lat);
      mem_b[11'h000] = 16'h5A3C; vld_b[11'h000] = 1;
      xfer_b(0, 2'b00, 11'h7FF, 16'h0, rdb, lat);
      chk("b_rd_7ff", rdb, 16'hA5C3);
      chk("b_lat", lat, 1);
      xfer_b(0, 2'b00, 11'h000, 16'h0, rdb, lat);
      chk("b_rd_000", rdb, 16'h5A3C);
      last_b = rdb;

      // strobe left high across the ACK-ending edge must not start a second transfer
      cyc_b = 1; stb_b = 1; we_b = 0; adr_b = 11'h7FF; acks = 0;
      @(negedge clk); acks += int'(ack_b);
      chk("b_held_dat", dout_b, 16'hA5C3);
      @(negedge clk); acks += int'(ack_b);
      cyc_b = 0; stb_b = 0;
      @(negedge clk); acks += int'(ack_b);
      @(negedge clk); acks += int'(ack_b);
      chk("b_held_acks", acks, 1);
      last_b = 16'hA5C3;

      bnd = '{11'h000, 11'h1FF, 11'h200, 11'h7FF};
      for (int i = 0; i < 150; i++) begin
         we = 1'($urandom_range(0, 1));
         adrb = (i % 5 == 0) ? bnd[$urandom_range(0, 3)] : 11'($urandom);
         datb = 16'($urandom);
         sel = 4'($urandom_range(0, 3));
         if (!vld_b[adrb]) begin we = 1; sel = 4'h3; end
         xfer_b(we, sel[1:0], adrb, datb, rdb, lat);
         chk("rand_b_lat", lat, 1);
         if (we) begin
            chk("rand_b_hold", rdb, last_b);
            mem_b[adrb] = 16'(merge(32'(mem_b[adrb]), 32'(datb), {2'b00, sel[1:0]}));
            vld_b[adrb] = 1;
         end else begin
            chk("rand_b_rd", rdb, mem_b[adrb]);
            last_b = rdb;
         end
      end

      // request raised during the clear waits for the first IDLE cycle
      rst_a = 1; @(negedge clk); rst_a = 0;
      lat = 0;
      repeat (10) begin @(negedge clk); lat++; end
      cyc_a = 1; stb_a = 1; we_a = 0; sel_a = 4'h0; adr_a = 10'h005;
      while (!ack_a && lat < 2000) begin @(negedge clk); lat++; end
      chk("held_req_cycle", lat, 513);
      chk("held_req_data", dout_a, 0);
      chk("held_req_busy", busy_a, 0);
      cyc_a = 0; stb_a = 0;
      @(negedge clk);
      chk("held_req_single", ack_a, 0);
      foreach (mem_a[i]) mem_a[i] = '0;
      last_a = '0;
      xfer_a(0, 4'hF, 10'h205, 32'h0, rd, lat);
      chk("cleared_205", rd, 0);

      // reset at clear cycle 300 restarts the full clear
      rst_a = 1; @(negedge clk); rst_a = 0;
      repeat (300) @(negedge clk);
      chk("mid_clear_busy", busy_a, 1);
      rst_a = 1; @(negedge clk); rst_a = 0;
      wait_clear("restart_clear_len");

      // reset asserted in the ACK cycle clears ack and data
      xfer_a(1, 4'hF, 10'h123, 32'h89ABCDEF, rd, lat);
      cyc_a = 1; stb_a = 1; we_a = 0; adr_a = 10'h123;
      @(negedge clk);
      chk("ackrst_ack", ack_a, 1);
      chk("ackrst_rd", dout_a, 32'h89ABCDEF);
      rst_a = 1; cyc_a = 0; stb_a = 0;
      @(negedge clk);
      chk("ackrst_ack_after", ack_a, 0);
      chk("ackrst_dat_after", dout_a, 0);
      rst_a = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
